// File: rtl/memory_access_stage_pkg.sv
// Shared types and helpers for the memory access stage: FSM encoding,
// byte-lane select/replicate functions and the default ack timeout.
package memory_access_stage_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  localparam int TIMEOUT_DEFAULT = 16;

  // Little-endian lane pick, zero-extended to a full word.
  function automatic logic [31:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {24'h0, b};
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [7:0] b);
    return {4{b}};
  endfunction

endpackage

// File: rtl/memory_access_stage_mem_addr_gen.sv
// Effective-address generation for LDR/STR: offset add/subtract, pre/post
// index selection, byte lane and byte-enable pattern.
module mem_addr_gen (
  input  logic [31:0] i_base,
  input  logic [31:0] i_offset,
  input  logic        i_pre,
  input  logic        i_up,
  input  logic        i_byte,
  output logic [31:0] o_offset_addr,
  output logic [31:0] o_access_addr,
  output logic [3:0]  o_be,
  output logic [1:0]  o_lane
);

  assign o_offset_addr = i_up ? (i_base + i_offset) : (i_base - i_offset);
  assign o_access_addr = i_pre ? o_offset_addr : i_base;
  assign o_lane        = o_access_addr[1:0];

  // Word accesses enable every lane; byte accesses only the addressed one.
  for (genvar gi = 0; gi < 4; gi++) begin : g_be
    assign o_be[gi] = ~i_byte | (o_lane == 2'(gi));
  end

endmodule

// File: rtl/memory_access_stage.sv
// ARM pipeline memory stage: accepts one instruction per handshake, runs a
// req/ack data-memory transaction with timeout, and registers the WB result.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_MEM,
  input  logic        memAccess_MEM,
  input  logic [31:0] Data1_MEM,
  input  logic [31:0] Data2_MEM,
  input  logic        prePostAddOffset_MEM,
  input  logic        upDownOffset_MEM,
  input  logic        byteOrWord_MEM,
  input  logic        writeBack_MEM,
  input  logic        loadStore_MEM,
  input  logic        writebackEnable_MEM,
  input  logic [3:0]  rd_MEM,
  input  logic [3:0]  rn_MEM,
  input  logic [31:0] writeData_MEM,
  output logic        stall_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] result_WB,
  output logic [3:0]  rd_WB,
  output logic        regWrite_WB,
  output logic        baseWrite_WB,
  output logic [3:0]  rn_WB,
  output logic [31:0] baseValue_WB,
  output logic        valid_WB,
  output logic        memFault_WB
);

  localparam int CW = $clog2(TIMEOUT);

  mem_state_t r_state, w_state_next;
  logic [CW-1:0] r_cnt;

  logic [31:0] r_base, r_offset, r_wdata;
  logic        r_pre, r_up, r_byte, r_wb, r_load, r_we;
  logic [3:0]  r_rd, r_rn;

  logic [31:0] w_offset_addr, w_access_addr;
  logic [3:0]  w_be;
  logic [1:0]  w_lane;

  mem_addr_gen u_addr_gen (
    .i_base       (r_base),
    .i_offset     (r_offset),
    .i_pre        (r_pre),
    .i_up         (r_up),
    .i_byte       (r_byte),
    .o_offset_addr(w_offset_addr),
    .o_access_addr(w_access_addr),
    .o_be         (w_be),
    .o_lane       (w_lane)
  );

  logic w_access, w_accept, w_done, w_abort, w_base_wr;
  logic [31:0] w_load_data;

  assign w_access = (r_state == ST_ACCESS);
  assign w_accept = (r_state == ST_IDLE) && valid_MEM;
  assign w_done   = w_access && dmem_ack;
  // Ack in the timeout cycle still completes normally.
  assign w_abort  = w_access && !dmem_ack && (r_cnt == CW'(TIMEOUT - 1));

  assign w_load_data = r_byte ? lane_select(dmem_rdata, w_lane) : dmem_rdata;
  assign w_base_wr   = (r_wb | ~r_pre) & ~(r_load & (r_rd == r_rn));

  assign stall_MEM  = w_access;
  assign dmem_req   = w_access;
  assign dmem_we    = w_access & ~r_load;
  assign dmem_be    = w_access ? w_be : 4'h0;
  assign dmem_addr  = w_access ? {w_access_addr[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = (w_access && !r_load) ?
                      (r_byte ? lane_replicate(r_wdata[7:0]) : r_wdata) : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (valid_MEM && memAccess_MEM) w_state_next = ST_ACCESS;
      ST_ACCESS: if (w_done || w_abort)          w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !w_access || w_done || w_abort) r_cnt <= '0;
    else                                         r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0; r_offset <= '0; r_wdata <= '0;
      r_pre  <= 1'b0; r_up <= 1'b0; r_byte <= 1'b0;
      r_wb   <= 1'b0; r_load <= 1'b0; r_we <= 1'b0;
      r_rd   <= '0; r_rn <= '0;
    end else if (w_accept && memAccess_MEM) begin
      r_base <= Data1_MEM; r_offset <= Data2_MEM; r_wdata <= writeData_MEM;
      r_pre  <= prePostAddOffset_MEM; r_up <= upDownOffset_MEM;
      r_byte <= byteOrWord_MEM; r_wb <= writeBack_MEM; r_load <= loadStore_MEM;
      r_we   <= writebackEnable_MEM; r_rd <= rd_MEM; r_rn <= rn_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_WB <= '0; rd_WB <= '0; regWrite_WB <= 1'b0; baseWrite_WB <= 1'b0;
      rn_WB <= '0; baseValue_WB <= '0; valid_WB <= 1'b0; memFault_WB <= 1'b0;
    end else begin
      valid_WB <= 1'b0;
      if (w_accept && !memAccess_MEM) begin
        result_WB    <= Data1_MEM;
        rd_WB        <= rd_MEM;
        regWrite_WB  <= writebackEnable_MEM;
        baseWrite_WB <= 1'b0;
        rn_WB        <= rn_MEM;
        baseValue_WB <= '0;
        memFault_WB  <= 1'b0;
        valid_WB     <= 1'b1;
      end else if (w_done) begin
        result_WB    <= r_load ? w_load_data : 32'h0;
        rd_WB        <= r_rd;
        regWrite_WB  <= r_load & r_we;
        baseWrite_WB <= w_base_wr;
        rn_WB        <= r_rn;
        baseValue_WB <= w_offset_addr;
        memFault_WB  <= 1'b0;
        valid_WB     <= 1'b1;
      end else if (w_abort) begin
        result_WB    <= '0;
        rd_WB        <= r_rd;
        regWrite_WB  <= 1'b0;
        baseWrite_WB <= 1'b0;
        rn_WB        <= r_rn;
        baseValue_WB <= '0;
        memFault_WB  <= 1'b1;
        valid_WB     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: an instruction-level model predicts
// bus and writeback values; a per-cycle monitor compares them with the DUT.
module tb_memory_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_MEM, memAccess_MEM;
  logic [31:0] Data1_MEM, Data2_MEM, writeData_MEM;
  logic        prePostAddOffset_MEM, upDownOffset_MEM, byteOrWord_MEM;
  logic        writeBack_MEM, loadStore_MEM, writebackEnable_MEM;
  logic [3:0]  rd_MEM, rn_MEM;
  logic        stall_MEM, dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [31:0] result_WB, baseValue_WB;
  logic [3:0]  rd_WB, rn_WB;
  logic        regWrite_WB, baseWrite_WB, valid_WB, memFault_WB;

  memory_access_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .valid_MEM(valid_MEM), .memAccess_MEM(memAccess_MEM),
    .Data1_MEM(Data1_MEM), .Data2_MEM(Data2_MEM),
    .prePostAddOffset_MEM(prePostAddOffset_MEM), .upDownOffset_MEM(upDownOffset_MEM),
    .byteOrWord_MEM(byteOrWord_MEM), .writeBack_MEM(writeBack_MEM),
    .loadStore_MEM(loadStore_MEM), .writebackEnable_MEM(writebackEnable_MEM),
    .rd_MEM(rd_MEM), .rn_MEM(rn_MEM), .writeData_MEM(writeData_MEM),
    .stall_MEM(stall_MEM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .result_WB(result_WB), .rd_WB(rd_WB),
    .regWrite_WB(regWrite_WB), .baseWrite_WB(baseWrite_WB), .rn_WB(rn_WB),
    .baseValue_WB(baseValue_WB), .valid_WB(valid_WB), .memFault_WB(memFault_WB)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mem, p, u, b, w, l, we;
    logic [31:0] d1, d2, wd;
    logic [3:0]  rd, rn;
  } instr_t;

  typedef struct {
    logic [31:0] result, base_value, addr, wdata;
    logic [3:0]  rd, rn, be;
    bit          reg_write, base_write, fault, we;
    int          stall;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t cur_bus;
  bit   mem_active = 1'b0;
  int   stall_run = 0;
  int   n_valid = 0;
  logic [31:0] last_result, last_base_value, last_wdata;
  logic [3:0]  last_be;
  bit          last_base_write, last_fault;
  int          last_stall;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Instruction-level view: what the memory bus and writeback must show.
  function automatic exp_t model(input instr_t in, input logic [31:0] rdata, input bit fault);
    exp_t e;
    logic [31:0] off_addr, ea;
    int lane;
    e = '{default: '0};
    e.rd = in.rd;
    e.rn = in.rn;
    if (!in.mem) begin
      e.result    = in.d1;
      e.reg_write = in.we;
      return e;
    end
    off_addr = in.u ? in.d1 + in.d2 : in.d1 - in.d2;
    ea       = in.p ? off_addr : in.d1;
    lane     = int'(ea % 4);
    e.addr   = ea - 32'(lane);
    e.be     = in.b ? 4'(1 << lane) : 4'hF;
    e.we     = !in.l;
    e.wdata  = in.b ? 32'(in.wd[7:0]) * 32'h01010101 : in.wd;
    e.result = !in.l ? 32'h0 : (in.b ? (rdata >> (8 * lane)) & 32'hFF : rdata);
    e.reg_write  = in.l && in.we;
    e.base_write = (in.w || !in.p) && !(in.l && in.rd == in.rn);
    e.base_value = off_addr;
    e.fault      = fault;
    if (fault) begin
      e.reg_write  = 1'b0;
      e.base_write = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      stall_run = 0;
    end else begin
      if (stall_MEM) stall_run++;
      if (mem_active) begin
        check("dmem_bus", dmem_req && stall_MEM && dmem_addr == cur_bus.addr &&
              dmem_be == cur_bus.be && dmem_we == cur_bus.we &&
              (!cur_bus.we || dmem_wdata == cur_bus.wdata),
              $sformatf("got req=%0b stall=%0b addr=%h be=%b we=%0b wdata=%h want addr=%h be=%b we=%0b wdata=%h",
                        dmem_req, stall_MEM, dmem_addr, dmem_be, dmem_we, dmem_wdata,
                        cur_bus.addr, cur_bus.be, cur_bus.we, cur_bus.wdata));
        last_wdata = dmem_wdata;
        last_be    = dmem_be;
      end else begin
        check("idle_bus", !dmem_req && !stall_MEM,
              $sformatf("got req=%0b stall=%0b want 0 0", dmem_req, stall_MEM));
      end
      if (valid_WB) begin
        exp_t e;
        n_valid++;
        if (q.size() == 0) begin
          check("unexpected_valid", 1'b0, $sformatf("got valid_WB=1 want 0"));
        end else begin
          e = q.pop_front();
          check("wb", rd_WB == e.rd && regWrite_WB == e.reg_write &&
                baseWrite_WB == e.base_write && memFault_WB == e.fault &&
                (e.fault || result_WB == e.result) &&
                (!e.base_write || (rn_WB == e.rn && baseValue_WB == e.base_value)) &&
                stall_run == e.stall,
                $sformatf("got res=%h rd=%0d rw=%0b bw=%0b rn=%0d bv=%h flt=%0b stall=%0d want res=%h rd=%0d rw=%0b bw=%0b rn=%0d bv=%h flt=%0b stall=%0d",
                          result_WB, rd_WB, regWrite_WB, baseWrite_WB, rn_WB, baseValue_WB,
                          memFault_WB, stall_run, e.result, e.rd, e.reg_write,
                          e.base_write, e.rn, e.base_value, e.fault, e.stall));
          $display("txn rd=%0d result=%h fault=%0b stall=%0d", rd_WB, result_WB, memFault_WB, stall_run);
        end
        last_result     = result_WB;
        last_base_value = baseValue_WB;
        last_base_write = baseWrite_WB;
        last_fault      = memFault_WB;
        last_stall      = stall_run;
        stall_run = 0;
      end
    end
  end

  task automatic drive(input instr_t in);
    memAccess_MEM = in.mem; Data1_MEM = in.d1; Data2_MEM = in.d2; writeData_MEM = in.wd;
    prePostAddOffset_MEM = in.p; upDownOffset_MEM = in.u; byteOrWord_MEM = in.b;
    writeBack_MEM = in.w; loadStore_MEM = in.l; writebackEnable_MEM = in.we;
    rd_MEM = in.rd; rn_MEM = in.rn;
    valid_MEM = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      check("wb_timeout", 1'b0, $sformatf("got %0d pending results want 0", q.size()));
      q.delete();
    end
  endtask

  // ack_cycle: 1-based ACCESS cycle carrying the ack; 0 = never ack.
  task automatic issue(input instr_t in, input int ack_cycle, input logic [31:0] rdata);
    exp_t e;
    @(posedge clk); #1;
    drive(in);
    e = model(in, rdata, in.mem && ack_cycle == 0);
    e.stall = !in.mem ? 0 : (ack_cycle == 0 ? TMO : ack_cycle);
    q.push_back(e);
    cur_bus = e;
    @(posedge clk); #1;
    valid_MEM = 1'b0;
    if (in.mem) begin
      mem_active = 1'b1;
      if (ack_cycle == 0) begin
        repeat (TMO) @(posedge clk);
        #1;
      end else begin
        repeat (ack_cycle - 1) begin @(posedge clk); #1; end
        dmem_ack = 1'b1; dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
      end
      mem_active = 1'b0;
    end
    wait_drain();
  endtask

  function automatic instr_t mk(input bit mem, p, u, b, w, l, we,
                                input logic [31:0] d1, d2, wd, input logic [3:0] rd, rn);
    instr_t in;
    in.mem = mem; in.p = p; in.u = u; in.b = b; in.w = w; in.l = l; in.we = we;
    in.d1 = d1; in.d2 = d2; in.wd = wd; in.rd = rd; in.rn = rn;
    return in;
  endfunction

  initial begin
    int v0;
    reset = 1'b1; valid_MEM = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    valid_MEM = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", {stall_MEM, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
          result_WB, rd_WB, regWrite_WB, baseWrite_WB, rn_WB, baseValue_WB,
          valid_WB, memFault_WB} == '0, "got nonzero output want all zero");

    // ALU pass-through
    issue(mk(0, 0, 0, 0, 0, 0, 1, 32'h1234, 0, 0, 4'd3, 4'd0), 0, 0);
    check("pass_result", last_result == 32'h1234, $sformatf("got %h want 00001234", last_result));

    // LDR word, pre-index, writeback, ack in cycle 3
    issue(mk(1, 1, 1, 0, 1, 1, 1, 32'h100, 32'h8, 0, 4'd1, 4'd2), 3, 32'hDEADBEEF);
    check("ldr_pin", last_result == 32'hDEADBEEF && last_base_value == 32'h108 &&
          last_base_write && last_stall == 3,
          $sformatf("got res=%h bv=%h bw=%0b stall=%0d want deadbeef 00000108 1 3",
                    last_result, last_base_value, last_base_write, last_stall));

    // STRB post-index subtract
    issue(mk(1, 0, 0, 1, 0, 0, 0, 32'h203, 32'h4, 32'h123456AB, 4'd5, 4'd6), 1, 0);
    check("strb_pin", last_be == 4'b1000 && last_wdata == 32'hABABABAB &&
          last_base_value == 32'h1FF && last_base_write,
          $sformatf("got be=%b wdata=%h bv=%h bw=%0b want 1000 abababab 000001ff 1",
                    last_be, last_wdata, last_base_value, last_base_write));

    // LDRB lane 1
    issue(mk(1, 1, 1, 1, 0, 1, 1, 32'h301, 32'h0, 0, 4'd7, 4'd8), 2, 32'h11223344);
    check("ldrb_pin", last_result == 32'h33, $sformatf("got %h want 00000033", last_result));

    // LDR with rd == rn and W: load wins
    issue(mk(1, 1, 1, 0, 1, 1, 1, 32'h400, 32'h4, 0, 4'd4, 4'd4), 1, 32'h55AA55AA);
    check("ld_rd_eq_rn", !last_base_write, $sformatf("got bw=%0b want 0", last_base_write));

    // STR word, pre-index subtract, no writeback
    issue(mk(1, 1, 0, 0, 0, 0, 0, 32'h1000, 32'h10, 32'hCAFEF00D, 4'd9, 4'd10), 2, 0);

    // Timeout abort
    issue(mk(1, 1, 1, 0, 1, 1, 1, 32'h500, 32'h4, 0, 4'd2, 4'd3), 0, 0);
    check("fault_pin", last_fault && last_stall == TMO,
          $sformatf("got flt=%0b stall=%0d want 1 %0d", last_fault, last_stall, TMO));

    // Ack in the final allowed cycle completes normally
    issue(mk(1, 1, 1, 0, 0, 1, 1, 32'h600, 32'h0, 0, 4'd2, 4'd3), TMO, 32'h0BADF00D);
    check("late_ack_pin", !last_fault && last_result == 32'h0BADF00D,
          $sformatf("got flt=%0b res=%h want 0 0badf00d", last_fault, last_result));

    // Ack while idle is ignored
    v0 = n_valid;
    @(posedge clk); #1 dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1 dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("idle_ack", n_valid == v0, $sformatf("got %0d valids want %0d", n_valid - v0, 0));

    // Reset during ACCESS discards the transaction
    v0 = n_valid;
    @(posedge clk); #1;
    drive(mk(1, 1, 1, 0, 0, 1, 1, 32'h700, 32'h0, 0, 4'd1, 4'd1));
    cur_bus = model(mk(1, 1, 1, 0, 0, 1, 1, 32'h700, 32'h0, 0, 4'd1, 4'd1), 0, 0);
    @(posedge clk); #1 valid_MEM = 1'b0; mem_active = 1'b1;
    @(posedge clk); #1 reset = 1'b1; mem_active = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("reset_access", !dmem_req && !stall_MEM && !valid_WB,
          $sformatf("got req=%0b stall=%0b valid=%0b want 0 0 0", dmem_req, stall_MEM, valid_WB));
    repeat (6) @(negedge clk);
    check("reset_no_valid", n_valid == v0, $sformatf("got %0d valids want 0", n_valid - v0));

    issue(mk(1, 1, 1, 0, 0, 1, 1, 32'h800, 32'h4, 0, 4'd6, 4'd0), 1, 32'h87654321);
    check("after_reset_pin", last_result == 32'h87654321,
          $sformatf("got %h want 87654321", last_result));

    issue(mk(0, 0, 0, 0, 0, 0, 0, 32'hFFFF0000, 0, 0, 4'd11, 4'd0), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory stage of the ARM pipeline, directly downstream of the execute register. Accepts one instruction per handshake, forms the effective address for LDR/STR (pre/post-index, add/subtract offset, byte/word), and runs a req/ack transaction to data memory with a timeout. It stalls upstream while busy and presents a registered result, with register-file and base-writeback controls, to the writeback register.

## Interface
- TIMEOUT, 16: max cycles waiting for dmem_ack before abort (≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- valid_MEM  in  1  instruction present from execute register
- memAccess_MEM  in  1  1 = LDR/STR, 0 = pass-through (ALU result in Data1)
- Data1_MEM / Data2_MEM  in  32  base (Rn) or ALU result / offset
- prePostAddOffset_MEM, upDownOffset_MEM, byteOrWord_MEM, writeBack_MEM, loadStore_MEM  in  1 each  P (1 = pre), U (1 = add), B (1 = byte), W, L (1 = load)
- writebackEnable_MEM  in  1  instruction writes rd
- rd_MEM, rn_MEM  in  4  destination / base register
- writeData_MEM  in  32  store data
- stall_MEM  out  1  upstream must hold inputs
- dmem_req, dmem_we  out  1  request / write
- dmem_be  out  4  byte enables
- dmem_addr, dmem_wdata  out  32  word-aligned address / write data
- dmem_rdata  in  32; dmem_ack  in  1
- result_WB  out  32  load data or passed ALU result
- rd_WB  out  4; regWrite_WB  out  1
- baseWrite_WB  out  1; rn_WB  out  4; baseValue_WB  out  32
- valid_WB  out  1  one-cycle result pulse
- memFault_WB  out  1  timeout abort, valid with valid_WB

## Operation
- States: IDLE, ACCESS.
- IDLE: on valid_MEM, capture all inputs.
  - memAccess_MEM = 0: result_WB = Data1_MEM, regWrite_WB = writebackEnable_MEM, baseWrite_WB = 0, valid_WB = 1 next cycle; stay in IDLE.
  - memAccess_MEM = 1: go to ACCESS.
- offsetAddr = U ? base + offset : base − offset, mod 2^32. accessAddr = P ? offsetAddr : base.
- dmem_addr = {accessAddr[31:2], 2'b00}. lane = accessAddr[1:0].
- Word access: dmem_be = 4'b1111, lane ignored (no rotation).
- Byte access: dmem_be = one-hot at lane; dmem_wdata = store byte replicated ×4; load = zero-extended rdata byte from lane (little-endian).
- Base writeback = W | ~P, value offsetAddr, rn_WB = rn. If the instruction is a load and rd == rn, the load wins: baseWrite_WB = 0.
- ACCESS: dmem_req = 1 and all dmem_* held stable until ack.
  - ack: register result and controls, valid_WB = 1, memFault_WB = 0, return to IDLE.
  - Wait counter reaches TIMEOUT without ack: abort with valid_WB = 1, memFault_WB = 1, regWrite_WB = 0, baseWrite_WB = 0; return to IDLE.
- Store: regWrite_WB = 0, result_WB = 0.

## Timing
- Reset: state IDLE, counter 0, every output 0 (including dmem_req, stall_MEM, valid_WB).
- Reset while in ACCESS: dmem_req drops at that edge, the transaction is discarded, and no valid_WB is produced.
- stall_MEM = (state == ACCESS), combinational from state. While high, inputs are ignored.
- Pass-through latency: 1 cycle. Memory op: capture edge → dmem_req high the next cycle. Ack in cycle k → valid_WB in cycle k+1, and the stage is IDLE in k+1 (it may accept a new instruction at the k+1 edge). Minimum memory-op latency: 2 cycles.
- Ack in the same cycle the counter hits TIMEOUT: ack wins, no fault.
- dmem_ack sampled only in ACCESS; ack in IDLE is ignored.
- valid_WB is high for exactly one cycle per accepted instruction. All WB outputs hold their values until the next valid_WB.

## Structure
- Shared package: FSM state encoding, the lane select/replicate helpers, and a TIMEOUT default constant.
- One sub-module, mem_addr_gen: combinational offsetAddr/accessAddr/dmem_be/lane computation. The FSM, counter and output registers live in the top.

## Test plan
- ALU pass-through, Data1 = 0x1234, rd = 3, we = 1 → next cycle valid_WB = 1, result_WB = 0x1234, regWrite_WB = 1, dmem_req never high.
- LDR word pre-index + W: base 0x100, offset 8, U = 1, ack after 3 cycles with rdata 0xDEADBEEF → dmem_addr 0x108, stall 3 cycles, result 0xDEADBEEF, baseValue 0x108, baseWrite_WB = 1.
- STRB post-index: base 0x203, offset 4, U = 0, data 0xAB → addr 0x200, be 4'b1000, wdata 0xABABABAB, baseValue 0x1FF, baseWrite_WB = 1.
- LDRB lane 1, rdata 0x11223344 → result 0x00000033. LDR with rd == rn and W = 1 → baseWrite_WB = 0.
- No ack, TIMEOUT = 4 → fault after 4 wait cycles: valid_WB = 1, memFault_WB = 1, regWrite_WB = 0. Separately, ack on cycle 4 → normal completion.
- Reset asserted in ACCESS → next cycle dmem_req = 0, stall_MEM = 0, no valid_WB; a following instruction completes normally.
